// File: rtl/im2col_spc_regintfc_pkg.sv
// -----------------------------------------------------------------------------
// im2col_spc_regintfc_pkg
// Shared definitions for the im2col_spc register-interface arbiter:
// FSM state encoding, default parameter values and a wrap-around helper.
// -----------------------------------------------------------------------------
package im2col_spc_regintfc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    localparam int unsigned DefNumReq        = 32'd4;
    localparam int unsigned DefTimeoutCycles = 32'd1023;

    // Index following idx in a ring of n entries.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/reg_pkg.sv
// -----------------------------------------------------------------------------
// reg_pkg
// Register-interface request/response types shared by the im2col_spc blocks
// and the AOPB bridge.
//   reg_req_t : addr, write, wdata, wstrb, valid   (master -> slave)
//   reg_rsp_t : rdata, error, ready                (slave  -> master)
// -----------------------------------------------------------------------------
package reg_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// File: rtl/im2col_spc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// im2col_spc_rr_arbiter
// Purely combinational round-robin pick: returns the first asserted request at
// or after ptr_i, wrapping modulo NumReq. The pointer register lives in the
// parent so it only moves on an actual grant.
//   req_i  : request vector
//   ptr_i  : highest-priority index
//   gnt_o  : one-hot grant (all zero when no request)
//   idx_o  : binary index of the grant
//   any_o  : at least one request present
// -----------------------------------------------------------------------------
module im2col_spc_rr_arbiter
    import im2col_spc_regintfc_pkg::*;
#(
    parameter  int unsigned NumReq = DefNumReq,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    // Scan the ring starting at ptr_i; the first hit wins.
    always_comb begin
        int unsigned sum_v;
        int unsigned cand_v;
        logic        found_v;
        gnt_o   = '0;
        idx_o   = '0;
        found_v = 1'b0;
        sum_v   = 32'd0;
        cand_v  = 32'd0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            sum_v  = 32'(ptr_i) + i;
            cand_v = (sum_v >= NumReq) ? (sum_v - NumReq) : sum_v;
            if (!found_v && req_i[IdxW'(cand_v)]) begin
                found_v                = 1'b1;
                gnt_o[IdxW'(cand_v)]   = 1'b1;
                idx_o                  = IdxW'(cand_v);
            end else begin
                found_v = found_v;
            end
        end
        any_o = found_v;
    end

endmodule

// File: rtl/im2col_spc_regintfc_arbiter.sv
// -----------------------------------------------------------------------------
// im2col_spc_regintfc_arbiter
// Shares the single im2col_spc register-interface master port between NumReq
// requesters. One command at a time: round-robin accept in IDLE, drive the
// registered request in ISSUE until ready (or timeout), return the result to
// the owner for one cycle in RESP.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_valid_i/ready_o   : per-requester handshake (ready is a one-hot,
//                           combinational accept pulse in IDLE)
//   req_write/addr/wdata/wstrb_i : flattened per-requester command fields
//   rsp_valid_o           : one-hot completion pulse
//   rsp_rdata_o/error_o   : result of the completing command (held after)
//   aopb_req_o/resp_i     : register-interface master port
//   busy_o                : high whenever a command is in flight
// TimeoutCycles = 0 disables the ready timeout.
// -----------------------------------------------------------------------------
module im2col_spc_regintfc_arbiter
    import im2col_spc_regintfc_pkg::*;
    import reg_pkg::*;
#(
    parameter int unsigned NumReq        = DefNumReq,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumReq-1:0]    req_valid_i,
    output logic [NumReq-1:0]    req_ready_o,
    input  logic [NumReq-1:0]    req_write_i,
    input  logic [NumReq*32-1:0] req_addr_i,
    input  logic [NumReq*32-1:0] req_wdata_i,
    input  logic [NumReq*4-1:0]  req_wstrb_i,
    output logic [NumReq-1:0]    rsp_valid_o,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output reg_req_t             aopb_req_o,
    input  reg_rsp_t             aopb_resp_i,
    output logic                 busy_o
);

    localparam int unsigned     IdxW      = $clog2(NumReq);
    localparam int unsigned     CntW      = (TimeoutCycles == 32'd0) ? 32'd1 : $clog2(TimeoutCycles + 32'd1);
    localparam logic [CntW-1:0] CntLast   = CntW'((TimeoutCycles == 32'd0) ? 32'd0 : (TimeoutCycles - 32'd1));
    localparam logic [CntW-1:0] CntMax    = CntW'(TimeoutCycles);
    localparam logic            TimeoutEn = (TimeoutCycles != 32'd0);

    arb_state_e        state_r, state_next_s;
    logic [IdxW-1:0]   rr_ptr_r;
    logic [IdxW-1:0]   owner_r;
    logic [CntW-1:0]   to_cnt_r;
    reg_req_t          aopb_req_r;
    logic [NumReq-1:0] rsp_valid_r;
    logic [31:0]       rsp_rdata_r;
    logic              rsp_error_r;
    logic              busy_r;

    logic              grant_s;
    logic              hit_ready_s;
    logic              hit_timeout_s;
    logic [NumReq-1:0] req_ready_s;
    logic [NumReq-1:0] arb_gnt_s;
    logic [IdxW-1:0]   arb_idx_s;
    logic              arb_any_s;

    logic [31:0]       addr_arr_s  [NumReq];
    logic [31:0]       wdata_arr_s [NumReq];
    logic [3:0]        wstrb_arr_s [NumReq];

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign addr_arr_s[g]  = req_addr_i[g*32 +: 32];
        assign wdata_arr_s[g] = req_wdata_i[g*32 +: 32];
        assign wstrb_arr_s[g] = req_wstrb_i[g*4 +: 4];
    end

    im2col_spc_rr_arbiter #(
        .NumReq (NumReq)
    ) u_rr_arbiter (
        .req_i  (req_valid_i),
        .ptr_i  (rr_ptr_r),
        .gnt_o  (arb_gnt_s),
        .idx_o  (arb_idx_s),
        .any_o  (arb_any_s)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode plus the accept / completion events it implies.
    always_comb begin
        state_next_s  = state_r;
        grant_s       = 1'b0;
        hit_ready_s   = 1'b0;
        hit_timeout_s = 1'b0;
        req_ready_s   = '0;
        case (state_r)
            ST_IDLE: begin
                if (arb_any_s) begin
                    grant_s      = 1'b1;
                    req_ready_s  = arb_gnt_s;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Ready beats a timeout expiring in the same cycle.
                if (aopb_resp_i.ready) begin
                    hit_ready_s  = 1'b1;
                    state_next_s = ST_RESP;
                end else if (TimeoutEn && (to_cnt_r == CntLast)) begin
                    hit_timeout_s = 1'b1;
                    state_next_s  = ST_RESP;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Command capture, master-port drive, timeout count and result return.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_r    <= '0;
            owner_r     <= '0;
            to_cnt_r    <= '0;
            aopb_req_r  <= '0;
            rsp_valid_r <= '0;
            rsp_rdata_r <= 32'd0;
            rsp_error_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= '0;
            busy_r      <= (state_next_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        aopb_req_r.valid <= 1'b1;
                        aopb_req_r.write <= req_write_i[arb_idx_s];
                        aopb_req_r.addr  <= addr_arr_s[arb_idx_s];
                        aopb_req_r.wdata <= req_write_i[arb_idx_s] ? wdata_arr_s[arb_idx_s] : 32'd0;
                        aopb_req_r.wstrb <= wstrb_arr_s[arb_idx_s];
                        owner_r          <= arb_idx_s;
                        rr_ptr_r         <= IdxW'(wrap_inc(32'(arb_idx_s), NumReq));
                        to_cnt_r         <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (hit_ready_s) begin
                        aopb_req_r.valid <= 1'b0;
                        rsp_rdata_r      <= aopb_req_r.write ? 32'd0 : aopb_resp_i.rdata;
                        rsp_error_r      <= aopb_resp_i.error;
                        rsp_valid_r      <= NumReq'(1'b1) << owner_r;
                    end else if (hit_timeout_s) begin
                        aopb_req_r.valid <= 1'b0;
                        rsp_rdata_r      <= 32'd0;
                        rsp_error_r      <= 1'b1;
                        rsp_valid_r      <= NumReq'(1'b1) << owner_r;
                    end else if (to_cnt_r != CntMax) begin
                        to_cnt_r <= to_cnt_r + CntW'(1'b1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Accept is combinational so the requester sees it in the grant cycle.
    assign req_ready_o = rst_i ? '0 : req_ready_s;
    assign aopb_req_o  = aopb_req_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_error_o = rsp_error_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_im2col_spc_regintfc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_im2col_spc_regintfc_arbiter
// Self-checking bench: reset values, a table of directed single-requester
// transactions, fairness from reset, reset during ISSUE, and randomized
// multi-requester traffic checked against a ring-scan grant model.
// -----------------------------------------------------------------------------
module tb_im2col_spc_regintfc_arbiter;
    import reg_pkg::*;

    localparam int NR = 4;
    localparam int TO = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_i;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_write;
    logic [NR-1:0]    rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_error;
    logic             busy;
    logic [31:0]      tb_addr  [NR];
    logic [31:0]      tb_wdata [NR];
    logic [3:0]       tb_wstrb [NR];
    logic [NR*32-1:0] addr_flat;
    logic [NR*32-1:0] wdata_flat;
    logic [NR*4-1:0]  wstrb_flat;
    reg_req_t         aopb_req;
    reg_rsp_t         aopb_resp;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign addr_flat[g*32 +: 32]  = tb_addr[g];
        assign wdata_flat[g*32 +: 32] = tb_wdata[g];
        assign wstrb_flat[g*4 +: 4]   = tb_wstrb[g];
    end

    im2col_spc_regintfc_arbiter #(
        .NumReq        (NR),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (addr_flat),
        .req_wdata_i (wdata_flat),
        .req_wstrb_i (wstrb_flat),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error),
        .aopb_req_o  (aopb_req),
        .aopb_resp_i (aopb_resp),
        .busy_o      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference grant: first requester in mask at or after ptr, scanning the ring.
    function automatic int model_pick(input logic [NR-1:0] mask, input int ptr);
        for (int i = 0; i < NR; i++) begin
            if (mask[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction starting in an IDLE cycle. delay = ISSUE cycle
    // index in which the slave answers ready; >= TO means it never answers.
    task automatic run_txn(input string tag, input logic [NR-1:0] mask, input int exp_g,
                           input int delay, input logic [31:0] srdata, input logic serr,
                           input logic [31:0] exp_rdata, input logic exp_err);
        int            cyc;
        int            exp_cycles;
        logic [NR-1:0] onehot;
        onehot     = NR'(1'b1) << exp_g;
        exp_cycles = (delay < TO) ? delay + 1 : TO;
        req_valid  = mask;
        #1;
        check({tag, " accept"}, 32'(req_ready), 32'(onehot));
        tick();
        req_valid = '0;
        cyc       = 0;
        while (aopb_req.valid === 1'b1 && cyc < 50) begin
            if (cyc == 0) begin
                check({tag, " write"}, 32'(aopb_req.write), 32'(req_write[exp_g]));
                check({tag, " addr"}, aopb_req.addr, tb_addr[exp_g]);
                check({tag, " wdata"}, aopb_req.wdata, req_write[exp_g] ? tb_wdata[exp_g] : 32'd0);
                check({tag, " wstrb"}, 32'(aopb_req.wstrb), 32'(tb_wstrb[exp_g]));
            end
            aopb_resp.ready = (cyc == delay);
            aopb_resp.rdata = (cyc == delay) ? srdata : (32'hBAD0_0000 + 32'(cyc));
            aopb_resp.error = (cyc == delay) ? serr : 1'b1;
            tick();
            aopb_resp.ready = 1'b0;
            cyc++;
        end
        check({tag, " valid_cycles"}, 32'(cyc), 32'(exp_cycles));
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(onehot));
        check({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
        check({tag, " rsp_error"}, 32'(rsp_error), 32'(exp_err));
        tick();
        check({tag, " rsp_pulse_end"}, 32'(rsp_valid), 32'd0);
        check({tag, " busy_idle"}, 32'(busy), 32'd0);
        check({tag, " rdata_hold"}, rsp_rdata, exp_rdata);
    endtask

    typedef struct {
        int          req;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          delay;
        logic [31:0] srdata;
        logic        serr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int k;
        int cyc;
        int last;
        rst_i     = 1'b1;
        req_valid = '0;
        req_write = '0;
        aopb_resp = '0;
        for (int i = 0; i < NR; i++) begin
            tb_addr[i]  = 32'd0;
            tb_wdata[i] = 32'd0;
            tb_wstrb[i] = 4'd0;
        end

        //           req wr   addr        wdata         strb  dly srdata        serr  exp_rdata     exp_err
        vecs[0] = '{1, 1'b1, 32'h10,     32'hDEADBEEF, 4'hF, 2,  32'h5555AAAA, 1'b0, 32'h0,        1'b0};
        vecs[1] = '{0, 1'b0, 32'h20,     32'hFFFF0000, 4'h3, 0,  32'h12345678, 1'b0, 32'h12345678, 1'b0};
        vecs[2] = '{3, 1'b1, 32'h44,     32'hA5A5A5A5, 4'h6, 1,  32'h77777777, 1'b1, 32'h0,        1'b1};
        vecs[3] = '{2, 1'b0, 32'h1000,   32'h0,        4'h8, 4,  32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0};
        vecs[4] = '{1, 1'b0, 32'h2000,   32'h0,        4'hF, 99, 32'h11111111, 1'b0, 32'h0,        1'b1};
        vecs[5] = '{0, 1'b1, 32'h3000,   32'h13572468, 4'hF, 99, 32'h22222222, 1'b0, 32'h0,        1'b1};
        vecs[6] = '{3, 1'b0, 32'hFFFFFFFC, 32'h0,      4'h1, 3,  32'h0BADF00D, 1'b1, 32'h0BADF00D, 1'b1};

        // Reset values.
        repeat (3) tick();
        check("rst aopb_req", 32'(aopb_req != '0), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst rsp_error", 32'(rsp_error), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        rst_i = 1'b0;

        // Fairness from reset: all requesters always valid, slave always ready.
        for (int i = 0; i < NR; i++) begin
            tb_addr[i] = 32'h100 + 32'(i);
        end
        req_valid       = '1;
        aopb_resp.ready = 1'b1;
        k    = 0;
        cyc  = 0;
        last = 0;
        while (k < 8 && cyc < 100) begin
            #1;
            if (req_ready != '0) begin
                check("fair order", 32'(req_ready), 32'(NR'(1'b1) << (k % NR)));
                if (k > 0) check("fair spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                k++;
            end
            tick();
            cyc++;
        end
        check("fair count", 32'(k), 32'd8);
        req_valid = '0;
        repeat (3) tick();
        aopb_resp.ready = 1'b0;
        ptr_m = 0;

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            req_write[vecs[v].req] = vecs[v].write;
            tb_addr[vecs[v].req]   = vecs[v].addr;
            tb_wdata[vecs[v].req]  = vecs[v].wdata;
            tb_wstrb[vecs[v].req]  = vecs[v].wstrb;
            run_txn($sformatf("vec%0d", v), NR'(1'b1) << vecs[v].req, vecs[v].req,
                    vecs[v].delay, vecs[v].srdata, vecs[v].serr, vecs[v].exp_rdata, vecs[v].exp_err);
            ptr_m = (vecs[v].req + 1) % NR;
        end

        // Reset while waiting in ISSUE: command dropped, no response, pointer back to 0.
        req_write[2] = 1'b0;
        tb_addr[2]   = 32'h5000;
        req_valid    = 4'b0100;
        #1;
        check("rstmid accept", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        check("rstmid issue_valid", 32'(aopb_req.valid), 32'd1);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rstmid valid_drop", 32'(aopb_req.valid), 32'd0);
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        check("rstmid no_rsp2", 32'(rsp_valid), 32'd0);
        ptr_m = 0;
        run_txn("rstmid next", 4'hF, model_pick(4'hF, ptr_m), 0, 32'h0F0F0F0F, 1'b0,
                req_write[0] ? 32'd0 : 32'h0F0F0F0F, 1'b0);
        ptr_m = 1;

        // Randomized traffic against the ring-scan model.
        for (int t = 0; t < 30; t++) begin
            logic [NR-1:0] mask;
            int            g;
            int            delay;
            logic [31:0]   srdata;
            logic          serr;
            logic          to;
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                req_write[i] = 1'($urandom_range(0, 1));
                tb_addr[i]   = $urandom;
                tb_wdata[i]  = $urandom;
                tb_wstrb[i]  = 4'($urandom_range(0, 15));
            end
            g      = model_pick(mask, ptr_m);
            delay  = $urandom_range(0, TO + 1);
            srdata = $urandom;
            serr   = 1'($urandom_range(0, 1));
            to     = (delay >= TO);
            run_txn($sformatf("rnd%0d", t), mask, g, delay, srdata, serr,
                    to ? 32'd0 : (req_write[g] ? 32'd0 : srdata), to ? 1'b1 : serr);
            ptr_m = (g + 1) % NR;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/im2col_spc_regintfc_arbiter.md
# im2col_spc_regintfc_arbiter

Round-robin arbiter sharing the single im2col_spc register-interface master port towards the AOPB between NumReq independent requesters (e.g. the im2col control FSM, the DMA-programming sequencer and the interrupt/status clear logic). It accepts one read or write command at a time, drives it on the reg_req_t port until ready, returns rdata/error to the owner and enforces a bounded wait via a timeout.

## Interface
- NumReq, 4: number of requesters, 2..8.
- TimeoutCycles, 1023: max cycles waiting for aopb_resp_i.ready; 0 disables timeout.
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  NumReq  per-requester command valid.
- req_ready_o  out  NumReq  one-hot accept pulse, one cycle.
- req_write_i  in  NumReq  1 = write, 0 = read.
- req_addr_i  in  NumReq x 32  command address.
- req_wdata_i  in  NumReq x 32  write data.
- req_wstrb_i  in  NumReq x 4  byte strobes.
- rsp_valid_o  out  NumReq  one-hot completion pulse, one cycle.
- rsp_rdata_o  out  32  read data of the completing command (0 for writes).
- rsp_error_o  out  1  aopb_resp_i.error, or 1 on timeout.
- aopb_req_o  out  reg_req_t  register-interface request.
- aopb_resp_i  in  reg_rsp_t  register-interface response.
- busy_o  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req_valid_i, grant the first set bit at or after rr_ptr (wrapping modulo NumReq); assert req_ready_o[g] same cycle (combinational); capture write/addr/wdata/wstrb and owner index g; rr_ptr <= (g+1) mod NumReq; -> ISSUE.
- ISSUE: aopb_req_o.valid=1 with registered fields; held stable until ready. On aopb_resp_i.ready: capture rdata (forced 0 if write) and error; -> RESP. If timeout counter reaches TimeoutCycles first: drop valid, rdata=0, error=1; -> RESP.
- RESP: rsp_valid_o[owner]=1 for exactly one cycle with rsp_rdata_o/rsp_error_o; -> IDLE.
- Timeout counter: clog2(TimeoutCycles+1) bits, cleared on entering ISSUE, increments each ISSUE cycle without ready; saturates; unused when TimeoutCycles=0.
- Requester rules: hold req_valid_i and fields until req_ready_o; may withdraw before grant. Requests are not sampled in ISSUE/RESP.
- Reads drive aopb_req_o.wdata=0, write=0; wstrb passed through as captured.
- rr_ptr advances only on grant; a lone requester is granted every transaction.

## Timing
- Reset values: aopb_req_o all fields 0 (valid=0, write=0, wstrb=0, addr=0, wdata=0); req_ready_o=0; rsp_valid_o=0; rsp_rdata_o=0; rsp_error_o=0; busy_o=0; rr_ptr=0; state IDLE.
- Accept at cycle t -> aopb valid at t+1 -> ready at t+1 gives rsp_valid_o at t+2 -> next accept earliest t+3. Minimum 3 cycles per transaction.
- aopb_req_o, rsp_rdata_o, rsp_error_o are registers; rsp_* hold last value outside RESP.
- Timeout: valid high for exactly TimeoutCycles cycles, then RESP next cycle.
- Ready in the same cycle the counter would expire: ready wins, error taken from aopb_resp_i.
- rst_i mid-ISSUE: next cycle valid=0, IDLE, no rsp_valid_o pulse, rr_ptr=0; owner's command is lost.

## Structure
- Shared package im2col_spc_regintfc_pkg: FSM state enum, default NumReq/TimeoutCycles localparams.
- Sub-module im2col_spc_rr_arbiter: combinational round-robin pick (req vector, rr_ptr -> one-hot grant + index), pointer register kept in the parent.
- reg_req_t/reg_rsp_t from reg_pkg.

## Test plan
- Single write: req 1 writes addr 0x10 data 0xDEADBEEF strobe 0xF, ready after 2 cycles -> one AOPB write with those fields, rsp_valid_o=4'b0010, error=0, rdata=0.
- Single read: req 0 reads 0x20, slave returns 0x12345678 with ready -> rsp_rdata_o=0x12345678 on rsp_valid_o[0].
- Fairness: all 4 requesters held valid for 8 transactions from reset -> grant order 0,1,2,3,0,1,2,3, ready immediate -> one transaction every 3 cycles.
- Timeout: TimeoutCycles=5, slave never ready -> valid high 5 cycles, then rsp_error_o=1, rsp_rdata_o=0, state IDLE.
- Error propagation: slave ready with error=1 on write -> rsp_error_o=1 to owner only.
- Reset mid-ISSUE: assert rst_i one cycle during wait -> valid 0 next cycle, no rsp pulse, next grant starts from requester 0.
